// File: rtl/dac_frame_decoder_pkg.sv
// Shared constants and types for the DAC SPI command path.
// The DAC transmitter imports the same opcodes so that both ends agree on the encoding.
package dac_frame_decoder_pkg;

  localparam int FRAME_BITS  = 24;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 5;
  localparam int NUM_CH      = 4;
  localparam int DATA_W      = 16;

  localparam logic [3:0] OP_WRITE_INPUT   = 4'h1;
  localparam logic [3:0] OP_UPDATE_OUTPUT = 4'h2;
  localparam logic [3:0] OP_WRITE_THROUGH = 4'h3;
  localparam logic [7:0] CMD_LOAD_A       = 8'h31;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] mask;
  } cmd_t;

  function automatic logic opcode_known(input logic [3:0] op);
    return (op == OP_WRITE_INPUT) || (op == OP_UPDATE_OUTPUT) || (op == OP_WRITE_THROUGH);
  endfunction

endpackage

// File: rtl/dac_frame_decoder_spi_input_sync.sv
// Synchronises CS, SCLK and DATA into the system clock domain and derives the
// edge strobes the decoder needs, all taken from the synchronised levels only.
module spi_input_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cs_i,
  input  logic sclk_i,
  input  logic data_i,
  output logic cs_o,
  output logic cs_rise_o,
  output logic cs_fall_o,
  output logic sclk_fall_o,
  output logic data_o
);

  // Bit order {data, sclk, cs}; CS idles high so reset release never looks like a frame start.
  localparam logic [2:0] RESET_VAL = 3'b001;

  logic [2:0] pins;
  logic [2:0] synced;
  logic [1:0] prev_q;

  assign pins = {data_i, sclk_i, cs_i};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      logic [STAGES-1:0] chain_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          chain_q <= {STAGES{RESET_VAL[gi]}};
        end else begin
          chain_q <= {chain_q[STAGES-2:0], pins[gi]};
        end
      end

      assign synced[gi] = chain_q[STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= RESET_VAL[1:0];
    end else begin
      prev_q <= synced[1:0];
    end
  end

  assign cs_o        = synced[0];
  assign cs_rise_o   = synced[0] & ~prev_q[0];
  assign cs_fall_o   = ~synced[0] & prev_q[0];
  assign sclk_fall_o = ~synced[1] & prev_q[1];
  assign data_o      = synced[2];

endmodule

// File: rtl/dac_frame_decoder.sv
// SPI command decoder for a four-channel DAC: shifts in {cmd, data} frames and
// applies write-input, update-output and write-through commands per channel mask.
module dac_frame_decoder
  import dac_frame_decoder_pkg::*;
#(
  parameter int FRAME_BITS  = dac_frame_decoder_pkg::FRAME_BITS,
  parameter int SYNC_STAGES = dac_frame_decoder_pkg::SYNC_STAGES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spi_cs_in,
  input  logic              spi_clock_in,
  input  logic              spi_data_in,
  output logic [DATA_W-1:0] dac_a_out,
  output logic [DATA_W-1:0] dac_b_out,
  output logic [DATA_W-1:0] dac_c_out,
  output logic [DATA_W-1:0] dac_d_out,
  output logic              frame_valid,
  output logic              frame_error,
  output logic [7:0]        last_cmd
);

  logic cs_lvl, cs_rise, cs_fall, sclk_fall, sdata;

  spi_input_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i       (clock),
    .rst_i       (reset),
    .cs_i        (spi_cs_in),
    .sclk_i      (spi_clock_in),
    .data_i      (spi_data_in),
    .cs_o        (cs_lvl),
    .cs_rise_o   (cs_rise),
    .cs_fall_o   (cs_fall),
    .sclk_fall_o (sclk_fall),
    .data_o      (sdata)
  );

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    frame_valid_q, frame_error_q;
  logic [7:0]              last_cmd_q;

  logic                    shift_en, clear_frame, commit_ok, commit_bad;
  cmd_t                    cmd;
  logic [DATA_W-1:0]       data;
  logic [NUM_CH-1:0][DATA_W-1:0] out_bus;

  assign cmd  = cmd_t'(sr_q[FRAME_BITS-1 -: 8]);
  assign data = sr_q[DATA_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cs_fall) state_d = ST_SHIFT;
      ST_SHIFT:  if (cs_rise) state_d = ST_COMMIT;
      ST_COMMIT: state_d = cs_fall ? ST_SHIFT : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // A falling SCLK that coincides with CS rising belongs to no frame.
  always_comb begin
    shift_en    = (state_q == ST_SHIFT) && sclk_fall && !cs_lvl && !cs_rise;
    clear_frame = cs_fall && (state_q != ST_SHIFT);
    commit_ok   = (state_q == ST_COMMIT) && (cnt_q == CNT_W'(FRAME_BITS))
                  && opcode_known(cmd.opcode) && (cmd.mask != 4'h0);
    commit_bad  = (state_q == ST_COMMIT) && !commit_ok;
  end

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clear_frame) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (shift_en) begin
      sr_d = {sr_q[FRAME_BITS-2:0], sdata};
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr_q          <= '0;
      cnt_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      last_cmd_q    <= 8'h00;
    end else begin
      sr_q          <= sr_d;
      cnt_q         <= cnt_d;
      frame_valid_q <= commit_ok;
      frame_error_q <= commit_bad;
      if (commit_ok) last_cmd_q <= cmd;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DATA_W-1:0] in_q, in_d, out_q, out_d;
      logic              sel;

      assign sel = commit_ok && cmd.mask[gi];

      always_comb begin
        in_d  = in_q;
        out_d = out_q;
        if (sel && (cmd.opcode == OP_WRITE_INPUT || cmd.opcode == OP_WRITE_THROUGH)) begin
          in_d = data;
        end
        if (sel && cmd.opcode == OP_WRITE_THROUGH) begin
          out_d = data;
        end else if (sel && cmd.opcode == OP_UPDATE_OUTPUT) begin
          out_d = in_q;
        end
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          in_q  <= '0;
          out_q <= '0;
        end else begin
          in_q  <= in_d;
          out_q <= out_d;
        end
      end

      assign out_bus[gi] = out_q;
    end
  endgenerate

  assign dac_a_out   = out_bus[0];
  assign dac_b_out   = out_bus[1];
  assign dac_c_out   = out_bus[2];
  assign dac_d_out   = out_bus[3];
  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;
  assign last_cmd    = last_cmd_q;

endmodule
